// File: rtl/binary_to_gray_converter_4_bit.sv
// -----------------------------------------------------------------------------
// binary_to_gray_converter_4_bit
//
// Purpose:
//   Registered 4-bit binary-to-Gray converter with a valid qualifier. It also
//   converts the registered Gray code back to binary, so the output can be
//   checked against the last accepted input. A monitor reports whether each
//   accepted Gray code differs from the previous accepted one in exactly one
//   bit. The block has a fixed latency of one cycle and accepts one value per
//   clock.
//
// Ports:
//   Clock                 in   system clock; all state updates on the rising edge
//   Reset                 in   synchronous, active-high reset
//   Binary_Code_In  [3:0] in   binary value to convert
//   Valid_In              in   when high, Binary_Code_In is accepted on this edge
//   Gray_Code_Out   [3:0] out  registered Gray code of the last accepted input
//   Valid_Out             out  high for one cycle after each accepted input
//   Binary_Code_Out [3:0] out  Gray_Code_Out converted back to binary
//                              (combinational from the register)
//   Single_Step_Out       out  last accepted Gray code differs from the one
//                              before it in exactly one bit
//   Conversion_Count_Out [7:0] out  accepted inputs since reset, wraps at 256
// -----------------------------------------------------------------------------
module binary_to_gray_converter_4_bit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Binary_Code_In,
  input  logic       Valid_In,
  output logic [3:0] Gray_Code_Out,
  output logic       Valid_Out,
  output logic [3:0] Binary_Code_Out,
  output logic       Single_Step_Out,
  output logic [7:0] Conversion_Count_Out
);

  logic [3:0] gray_q, gray_d;
  logic       valid_q, valid_d;
  logic       single_step_q, single_step_d;
  logic [7:0] count_q, count_d;
  logic       have_prev_q, have_prev_d;

  logic [3:0] gray_conv;
  logic [3:0] gray_diff;
  logic       one_bit_diff;
  logic [3:0] binary_back;

  // Forward conversion: G = B ^ (B >> 1). The MSB passes through unchanged.
  assign gray_conv[3] = Binary_Code_In[3];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
      assign gray_conv[gi] = Binary_Code_In[gi+1] ^ Binary_Code_In[gi];
    end
  endgenerate

  // Back-conversion: each binary bit is the XOR of all Gray bits at or above
  // it. This is the unrolled form of the prefix chain B[i] = B[i+1] ^ G[i].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_back
      assign binary_back[gi] = ^gray_q[3:gi];
    end
  endgenerate

  // Exactly one bit set <=> nonzero and clearing the lowest set bit gives zero.
  assign gray_diff    = gray_conv ^ gray_q;
  assign one_bit_diff = (gray_diff != 4'd0) && ((gray_diff & (gray_diff - 4'd1)) == 4'd0);

  always_comb begin
    gray_d        = gray_q;
    single_step_d = single_step_q;
    count_d       = count_q;
    have_prev_d   = have_prev_q;
    valid_d       = Valid_In;
    // The data path is only looked at when Valid_In is high, so an undriven or
    // X input does nothing while idle.
    if (Valid_In) begin
      gray_d        = gray_conv;
      single_step_d = have_prev_q && one_bit_diff;
      count_d       = count_q + 8'd1;
      have_prev_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      gray_q        <= 4'd0;
      valid_q       <= 1'b0;
      single_step_q <= 1'b0;
      count_q       <= 8'd0;
      have_prev_q   <= 1'b0;
    end else begin
      gray_q        <= gray_d;
      valid_q       <= valid_d;
      single_step_q <= single_step_d;
      count_q       <= count_d;
      have_prev_q   <= have_prev_d;
    end
  end

  assign Gray_Code_Out        = gray_q;
  assign Valid_Out            = valid_q;
  assign Binary_Code_Out      = binary_back;
  assign Single_Step_Out      = single_step_q;
  assign Conversion_Count_Out = count_q;

endmodule

// File: tb/tb_binary_to_gray_converter_4_bit.sv
// -----------------------------------------------------------------------------
// tb_binary_to_gray_converter_4_bit
//
// Purpose:
//   Self-checking bench for binary_to_gray_converter_4_bit. It drives a
//   table-driven sweep, hand-written corner-case sequences and random
//   stimulus. Outputs are compared with a reference model. The model builds
//   the Gray sequence by reflect-and-prefix and tracks the accepted history.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_binary_to_gray_converter_4_bit;

  logic       clk;
  logic       rst;
  logic [3:0] bin_in;
  logic       valid_in;
  logic [3:0] gray_out;
  logic       valid_out;
  logic [3:0] bin_out;
  logic       ss_out;
  logic [7:0] cnt_out;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model state
  int gray_list [16];
  int m_gray, m_bin, m_cnt;
  bit m_valid, m_ss, m_have;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       ss;
  } vec_t;
  vec_t sweep [16];

  binary_to_gray_converter_4_bit dut (
    .Clock                (clk),
    .Reset                (rst),
    .Binary_Code_In       (bin_in),
    .Valid_In             (valid_in),
    .Gray_Code_Out        (gray_out),
    .Valid_Out            (valid_out),
    .Binary_Code_Out      (bin_out),
    .Single_Step_Out      (ss_out),
    .Conversion_Count_Out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (txn %0d)", name, act, exp, txn);
    end
  endtask

  // One clock: drive inputs, wait for the edge, update the model, compare.
  task automatic cyc(input bit r, input bit v, input logic [3:0] b);
    int g;
    rst      = r;
    valid_in = v;
    bin_in   = b;
    @(posedge clk);
    #1;
    txn++;
    if (r) begin
      m_gray = 0; m_bin = 0; m_cnt = 0; m_valid = 0; m_ss = 0; m_have = 0;
    end else if (v) begin
      g       = gray_list[b];
      m_ss    = m_have && ($countones(g ^ m_gray) == 1);
      m_gray  = g;
      m_bin   = int'(b);
      m_cnt   = (m_cnt + 1) % 256;
      m_have  = 1;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    $display("txn %0d rst=%0b vin=%0b b=%b -> gray=%b bin=%b vout=%0b ss=%0b cnt=%0d",
             txn, r, v, b, gray_out, bin_out, valid_out, ss_out, cnt_out);
    chk("gray",  int'(gray_out),  m_gray);
    chk("bin",   int'(bin_out),   m_bin);
    chk("valid", int'(valid_out), int'(m_valid));
    chk("ss",    int'(ss_out),    int'(m_ss));
    chk("count", int'(cnt_out),   m_cnt);
  endtask

  initial begin
    // Reflected Gray sequence: prefix 1 onto the mirrored lower half.
    gray_list[0] = 0;
    gray_list[1] = 1;
    for (int n = 1; n < 4; n++)
      for (int k = 0; k < (1 << n); k++)
        gray_list[(1 << (n + 1)) - 1 - k] = gray_list[k] | (1 << n);

    m_gray = 0; m_bin = 0; m_cnt = 0; m_valid = 0; m_ss = 0; m_have = 0;

    sweep[0]  = '{4'd0,  4'b0000, 1'b0};
    sweep[1]  = '{4'd1,  4'b0001, 1'b1};
    sweep[2]  = '{4'd2,  4'b0011, 1'b1};
    sweep[3]  = '{4'd3,  4'b0010, 1'b1};
    sweep[4]  = '{4'd4,  4'b0110, 1'b1};
    sweep[5]  = '{4'd5,  4'b0111, 1'b1};
    sweep[6]  = '{4'd6,  4'b0101, 1'b1};
    sweep[7]  = '{4'd7,  4'b0100, 1'b1};
    sweep[8]  = '{4'd8,  4'b1100, 1'b1};
    sweep[9]  = '{4'd9,  4'b1101, 1'b1};
    sweep[10] = '{4'd10, 4'b1111, 1'b1};
    sweep[11] = '{4'd11, 4'b1110, 1'b1};
    sweep[12] = '{4'd12, 4'b1010, 1'b1};
    sweep[13] = '{4'd13, 4'b1011, 1'b1};
    sweep[14] = '{4'd14, 4'b1001, 1'b1};
    sweep[15] = '{4'd15, 4'b1000, 1'b1};

    rst = 1'b1; valid_in = 1'b0; bin_in = 4'd0;

    // Reset state
    cyc(1, 0, 4'd0);
    chk("reset_gray",  int'(gray_out), 0);
    chk("reset_count", int'(cnt_out),  0);

    // Exhaustive sweep against the table
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, sweep[i].b);
      chk("sweep_gray",  int'(gray_out),  int'(sweep[i].g));
      chk("sweep_bin",   int'(bin_out),   int'(sweep[i].b));
      chk("sweep_ss",    int'(ss_out),    int'(sweep[i].ss));
      chk("sweep_valid", int'(valid_out), 1);
    end
    chk("sweep_count", int'(cnt_out), 16);

    // Specific values
    cyc(0, 1, 4'b0101); chk("spec_0101", int'(gray_out), 4'b0111);
    cyc(0, 1, 4'b1111); chk("spec_1111", int'(gray_out), 4'b1000);
    cyc(0, 1, 4'b0111); chk("spec_0111", int'(gray_out), 4'b0100);
    cyc(0, 1, 4'b1000); chk("spec_1000", int'(gray_out), 4'b1100);
    chk("spec_step_78", int'(ss_out), 1);
    cyc(0, 1, 4'b0011); chk("spec_0011", int'(gray_out), 4'b0010);
    cyc(0, 1, 4'b0101); chk("spec_0101b", int'(gray_out), 4'b0111);
    chk("spec_step_35", int'(ss_out), 0);

    // Hold with changing input while idle
    cyc(0, 1, 4'b1010); chk("hold_load", int'(gray_out), 4'b1111);
    begin
      int c0;
      c0 = int'(cnt_out);
      for (int i = 0; i < 5; i++) begin
        cyc(0, 0, 4'($urandom_range(0, 15)));
        chk("hold_gray",  int'(gray_out),  4'b1111);
        chk("hold_valid", int'(valid_out), 0);
        chk("hold_count", int'(cnt_out),   c0);
      end
    end

    // Random accepts
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 4'($urandom_range(0, 15)));

    // Random mix of idle and accept
    for (int i = 0; i < 30; i++)
      cyc(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Reset mid-stream wins over Valid_In
    cyc(0, 1, 4'b0110);
    cyc(1, 1, 4'b1111);
    chk("rst_gray",  int'(gray_out),  0);
    chk("rst_bin",   int'(bin_out),   0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_ss",    int'(ss_out),    0);
    chk("rst_count", int'(cnt_out),   0);
    cyc(0, 1, 4'b0001);
    chk("post_rst_gray",  int'(gray_out), 4'b0001);
    chk("post_rst_ss",    int'(ss_out),   0);
    chk("post_rst_count", int'(cnt_out),  1);

    // Counter wrap: reset, then 256 accepts
    cyc(1, 0, 4'd0);
    for (int i = 0; i < 256; i++)
      cyc(0, 1, 4'(i % 16));
    chk("wrap_count", int'(cnt_out), 0);

    // Binary wrap 15 -> 0 is a single Gray step
    cyc(0, 1, 4'd15);
    cyc(0, 1, 4'd0);
    chk("wrap_15_0_ss", int'(ss_out), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
